// File: rtl/blinker_pkg.sv
// Shared types and sizing helpers for the event blinker and related UI output blocks.
package blinker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_e;

  // Timer width covering the longer of the two window lengths (at least 1 bit).
  function automatic int timer_w(input int on_cycles, input int gap_cycles);
    int m;
    m = (on_cycles > gap_cycles) ? on_cycles : gap_cycles;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Free-running cycle counter with synchronous clear; flags the last cycle of a window.
module cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic [W:0]   limit_i,
  output logic         done_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = clear_i ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  // limit_i is one bit wider than the count so a power-of-two limit stays representable.
  assign done_o = ({1'b0, count_q} == (limit_i - 1'b1));

endmodule

// File: rtl/event_blinker.sv
// Turns single-cycle event pulses into ON/GAP output windows, queueing events
// that arrive while a window is running in a saturating pending counter.
module event_blinker
  import blinker_pkg::*;
#(
  parameter int ON_CYCLES  = 5_000_000,
  parameter int GAP_CYCLES = 5_000_000,
  parameter int PEND_W     = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              evt_in,
  output logic              out_drv,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              overflow
);

  localparam int              TW       = timer_w(ON_CYCLES, GAP_CYCLES);
  localparam logic [TW:0]     ON_LIM   = ON_CYCLES[TW:0];
  localparam logic [TW:0]     GAP_LIM  = GAP_CYCLES[TW:0];
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  state_e            state_q, state_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              out_q, out_d;
  logic              ovf_q, ovf_d;
  logic              start;
  logic              tmr_clear;
  logic              tmr_done;
  logic [TW:0]       tmr_limit;

  assign tmr_limit = (state_q == ON) ? ON_LIM : GAP_LIM;

  cycle_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear_i (tmr_clear),
    .limit_i (tmr_limit),
    .done_o  (tmr_done)
  );

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_q != '0) begin
          start   = 1'b1;
          state_d = ON;
        end
      end
      ON: begin
        if (tmr_done) state_d = GAP;
      end
      GAP: begin
        if (tmr_done) begin
          if (pend_q != '0) begin
            start   = 1'b1;
            state_d = ON;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Simultaneous inc/dec leaves the count alone, so nothing is dropped at saturation.
    pend_d = pend_q;
    ovf_d  = 1'b0;
    if (evt_in && !start) begin
      if (pend_q != PEND_MAX) pend_d = pend_q + 1'b1;
      else                    ovf_d  = 1'b1;
    end else if (start && !evt_in) begin
      pend_d = pend_q - 1'b1;
    end

    tmr_clear = (state_d != state_q) || (state_q == IDLE);
    out_d     = (state_d == ON) ^ ACTIVE_LOW;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      out_q   <= ACTIVE_LOW;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_drv  = out_q;
  assign pend_cnt = pend_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != IDLE) || (pend_q != '0);

endmodule

// File: tb/tb_event_blinker.sv
// Scoreboard bench for event_blinker with ON=3, GAP=2, PEND_W=2; an ACTIVE_LOW
// twin shares all inputs so its drive polarity is checked on every cycle.
module tb_event_blinker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       evt_in = 1'b0;
  logic       out_drv, busy, overflow;
  logic [1:0] pend_cnt;
  logic       out_al, busy_al, ovf_al;
  logic [1:0] pend_al;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       out;
    logic [1:0] pend;
    logic       busy;
    logic       ovf;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  event_blinker #(.ON_CYCLES(3), .GAP_CYCLES(2), .PEND_W(2), .ACTIVE_LOW(1'b0)) u_dut (
    .clk(clk), .rst(rst), .evt_in(evt_in),
    .out_drv(out_drv), .busy(busy), .pend_cnt(pend_cnt), .overflow(overflow)
  );

  event_blinker #(.ON_CYCLES(3), .GAP_CYCLES(2), .PEND_W(2), .ACTIVE_LOW(1'b1)) u_dut_al (
    .clk(clk), .rst(rst), .evt_in(evt_in),
    .out_drv(out_al), .busy(busy_al), .pend_cnt(pend_al), .overflow(ovf_al)
  );

  task automatic do_reset();
    rst = 1'b1; evt_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1; evt_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin rst = 1'b0; evt_in = 1'b0; end
      e = '{out: 1'b0, pend: 2'd0, busy: 1'b0, ovf: 1'b0};
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++; if (out_drv !== e.out) begin n_fail++; $display("FAIL reset.out k=%0d got %b exp %b", k, out_drv, e.out); end
      n_checks++; if (out_al !== ~e.out) begin n_fail++; $display("FAIL reset.out_al k=%0d got %b exp %b", k, out_al, ~e.out); end
      n_checks++; if (pend_cnt !== e.pend) begin n_fail++; $display("FAIL reset.pend k=%0d got %0d exp %0d", k, pend_cnt, e.pend); end
      n_checks++; if (busy !== e.busy) begin n_fail++; $display("FAIL reset.busy k=%0d got %b exp %b", k, busy, e.busy); end
      n_checks++; if (overflow !== e.ovf) begin n_fail++; $display("FAIL reset.ovf k=%0d got %b exp %b", k, overflow, e.ovf); end
    end
  endtask

  task automatic test_single();
    int ev[1:8]   = '{1,0,0,0,0,0,0,0};
    int eo[1:8]   = '{0,1,1,1,0,0,0,0};
    int ep[1:8]   = '{1,0,0,0,0,0,0,0};
    int eb[1:8]   = '{1,1,1,1,1,1,0,0};
    exp_t e;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      evt_in = (ev[k] != 0);
      e = '{out: eo[k][0], pend: ep[k][1:0], busy: eb[k][0], ovf: 1'b0};
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++; if (out_drv !== e.out) begin n_fail++; $display("FAIL single.out c%0d got %b exp %b", k, out_drv, e.out); end
      n_checks++; if (out_al !== ~e.out) begin n_fail++; $display("FAIL single.out_al c%0d got %b exp %b", k, out_al, ~e.out); end
      n_checks++; if (pend_cnt !== e.pend) begin n_fail++; $display("FAIL single.pend c%0d got %0d exp %0d", k, pend_cnt, e.pend); end
      n_checks++; if (busy !== e.busy) begin n_fail++; $display("FAIL single.busy c%0d got %b exp %b", k, busy, e.busy); end
      n_checks++; if (overflow !== e.ovf) begin n_fail++; $display("FAIL single.ovf c%0d got %b exp %b", k, overflow, e.ovf); end
    end
    evt_in = 1'b0;
  endtask

  task automatic test_back_to_back();
    int ev[1:13] = '{1,1,0,0,0,0,0,0,0,0,0,0,0};
    int eo[1:13] = '{0,1,1,1,0,0,1,1,1,0,0,0,0};
    int ep[1:13] = '{1,1,1,1,1,1,0,0,0,0,0,0,0};
    int eb[1:13] = '{1,1,1,1,1,1,1,1,1,1,1,0,0};
    exp_t e;
    do_reset();
    for (int k = 1; k <= 13; k++) begin
      evt_in = (ev[k] != 0);
      e = '{out: eo[k][0], pend: ep[k][1:0], busy: eb[k][0], ovf: 1'b0};
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++; if (out_drv !== e.out) begin n_fail++; $display("FAIL b2b.out c%0d got %b exp %b", k, out_drv, e.out); end
      n_checks++; if (out_al !== ~e.out) begin n_fail++; $display("FAIL b2b.out_al c%0d got %b exp %b", k, out_al, ~e.out); end
      n_checks++; if (pend_cnt !== e.pend) begin n_fail++; $display("FAIL b2b.pend c%0d got %0d exp %0d", k, pend_cnt, e.pend); end
      n_checks++; if (busy !== e.busy) begin n_fail++; $display("FAIL b2b.busy c%0d got %b exp %b", k, busy, e.busy); end
      n_checks++; if (overflow !== e.ovf) begin n_fail++; $display("FAIL b2b.ovf c%0d got %b exp %b", k, overflow, e.ovf); end
    end
    evt_in = 1'b0;
  endtask

  task automatic test_saturation();
    int ev[1:8] = '{1,0,1,1,1,1,0,0};
    int eo[1:8] = '{0,1,1,1,0,0,1,1};
    int ep[1:8] = '{1,0,1,2,3,3,2,2};
    int ef[1:8] = '{0,0,0,0,0,1,0,0};
    exp_t e;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      evt_in = (ev[k] != 0);
      e = '{out: eo[k][0], pend: ep[k][1:0], busy: 1'b1, ovf: ef[k][0]};
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++; if (out_drv !== e.out) begin n_fail++; $display("FAIL sat.out c%0d got %b exp %b", k, out_drv, e.out); end
      n_checks++; if (pend_cnt !== e.pend) begin n_fail++; $display("FAIL sat.pend c%0d got %0d exp %0d", k, pend_cnt, e.pend); end
      n_checks++; if (busy !== e.busy) begin n_fail++; $display("FAIL sat.busy c%0d got %b exp %b", k, busy, e.busy); end
      n_checks++; if (overflow !== e.ovf) begin n_fail++; $display("FAIL sat.ovf c%0d got %b exp %b", k, overflow, e.ovf); end
      n_checks++; if (ovf_al !== e.ovf) begin n_fail++; $display("FAIL sat.ovf_al c%0d got %b exp %b", k, ovf_al, e.ovf); end
    end
    evt_in = 1'b0;
  endtask

  task automatic test_inc_dec_at_max();
    int ev[1:8] = '{1,0,1,1,1,0,1,0};
    int eo[1:8] = '{0,1,1,1,0,0,1,1};
    int ep[1:8] = '{1,0,1,2,3,3,3,3};
    exp_t e;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      evt_in = (ev[k] != 0);
      e = '{out: eo[k][0], pend: ep[k][1:0], busy: 1'b1, ovf: 1'b0};
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++; if (out_drv !== e.out) begin n_fail++; $display("FAIL incdec.out c%0d got %b exp %b", k, out_drv, e.out); end
      n_checks++; if (pend_cnt !== e.pend) begin n_fail++; $display("FAIL incdec.pend c%0d got %0d exp %0d", k, pend_cnt, e.pend); end
      n_checks++; if (busy !== e.busy) begin n_fail++; $display("FAIL incdec.busy c%0d got %b exp %b", k, busy, e.busy); end
      n_checks++; if (overflow !== e.ovf) begin n_fail++; $display("FAIL incdec.ovf c%0d got %b exp %b", k, overflow, e.ovf); end
    end
    evt_in = 1'b0;
  endtask

  task automatic test_reset_mid_on();
    int ev[1:13] = '{1,0,1,1,0,1,0,0,0,0,0,0,0};
    int eo[1:13] = '{0,1,1,1,0,0,1,1,1,0,0,0,0};
    int ep[1:13] = '{1,0,1,2,0,1,0,0,0,0,0,0,0};
    int eb[1:13] = '{1,1,1,1,0,1,1,1,1,1,1,0,0};
    exp_t e;
    do_reset();
    for (int k = 1; k <= 13; k++) begin
      evt_in = (ev[k] != 0);
      rst    = (k == 5);
      e = '{out: eo[k][0], pend: ep[k][1:0], busy: eb[k][0], ovf: 1'b0};
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++; if (out_drv !== e.out) begin n_fail++; $display("FAIL rstmid.out c%0d got %b exp %b", k, out_drv, e.out); end
      n_checks++; if (out_al !== ~e.out) begin n_fail++; $display("FAIL rstmid.out_al c%0d got %b exp %b", k, out_al, ~e.out); end
      n_checks++; if (pend_cnt !== e.pend) begin n_fail++; $display("FAIL rstmid.pend c%0d got %0d exp %0d", k, pend_cnt, e.pend); end
      n_checks++; if (busy !== e.busy) begin n_fail++; $display("FAIL rstmid.busy c%0d got %b exp %b", k, busy, e.busy); end
      n_checks++; if (overflow !== e.ovf) begin n_fail++; $display("FAIL rstmid.ovf c%0d got %b exp %b", k, overflow, e.ovf); end
    end
    rst = 1'b0;
    evt_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_saturation();
    test_inc_dec_at_max();
    test_reset_mid_on();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard.drain left %0d entries, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
